mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//   Iterative 32-bit multiply/divide unit for the single-cycle CPU datapath. It takes ALU operands
//   and writes results into HI/LO registers, which the writeback MUX reads on MFHI/MFLO.
//   A start/busy/done handshake lets the control unit stall PC-register loads while an operation runs.
//   Multiply uses shift-add; divide uses restoring division, one bit per clock.
// PARAMETERS
//   WIDTH   32   operand and result-half width in bits; latency scales with WIDTH
// PORTS
//   clk           input   1      rising-edge clock
//   rst           input   1      asynchronous, active-low reset
//   start         input   1      request an operation; sampled only while busy=0
//   op            input   2      00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed)
//   a             input   WIDTH  multiplicand / dividend; captured when start is accepted
//   b             input   WIDTH  multiplier / divisor; captured when start is accepted
//   busy          output  1      1 while an operation is in flight (state != IDLE)
//   done          output  1      one-cycle pulse; hi/lo hold the new result in the same cycle
//   div_by_zero   output  1      registered with done; 1 when a divide had b==0
//   hi            output  WIDTH  MUL: upper product half; DIV: remainder
//   lo            output  WIDTH  MUL: lower product half; DIV: quotient
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, count=0.
//   - States: IDLE -> CALC on an accepted start; CALC -> FIN after WIDTH iterations; FIN -> IDLE.
//   - Acceptance: start=1 at a clock edge while in IDLE.
//     That edge captures op, a and b and enters CALC with count=0.
//     start while busy=1 is ignored. a, b and op changes during busy are ignored.
//   - CALC: one iteration per edge; count increments 0..WIDTH-1.
//   - Entering FIN: taken at the edge where count==WIDTH-1 completes.
//   - Leaving FIN: at the next edge hi/lo load, done<=1, div_by_zero updates and state<=IDLE.
//   - Latency: the accept edge is E. done=1 and new hi/lo are visible after edge E+WIDTH+2.
//     busy=1 after edges E+1 .. E+WIDTH+1.
//   - done is 1 for exactly one cycle.
//   - Back-to-back: a start in the cycle where done=1 is accepted, because state is IDLE.
//   - hi and lo change only at the FIN->IDLE edge or on reset. They otherwise hold, including while busy.
//   - Signed ops: iterate on magnitudes |a| and |b|, then fix signs in FIN.
//     Product is negated when signs differ. The quotient is truncated toward zero.
//     The remainder takes the dividend's sign.
//   - Overflow: DIV of most-negative / -1 gives lo=most-negative and hi=0 (WIDTH-bit wrap). No flag.
//   - Divide by zero: full latency still applies. lo=all ones, hi=a (as captured), div_by_zero=1.
//   - div_by_zero is 0 for every multiply and for every divide with b!=0.
//   - Reset mid-operation: the operation aborts immediately. No done pulse; all outputs take reset values.
//   - Products are the full 2*WIDTH bits ({hi,lo}). No truncation or saturation.
// TESTING
//   1. MULTU a=FFFFFFFF b=FFFFFFFF -> hi=FFFFFFFE lo=00000001; done exactly 34 edges after the accept edge.
//   2. MULT a=FFFFFFFD(-3) b=7 -> hi=FFFFFFFF lo=FFFFFFEB. MULT a=-1 b=-1 -> hi=0 lo=1.
//   3. DIVU a=100 b=7 -> lo=14 hi=2. DIV a=-7 b=2 -> lo=FFFFFFFD hi=FFFFFFFF; div_by_zero=0 for both.
//   4. DIVU a=5 b=0 -> lo=FFFFFFFF hi=5 div_by_zero=1. DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=0.
//   5. Start MULTU 3*4, then pulse start with DIVU 9/3 at iteration 5 -> second request ignored; hi=0 lo=12.
//      Then start during the done cycle -> that request is accepted.
//   6. Start a DIVU; drive rst=0 at iteration 10 -> busy=0 hi=0 lo=0 immediately, and no done follows.
//      Then release reset, issue MULTU 2*3 -> lo=6 hi=0.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit writing HI/LO (shift-add multiply, restoring divide).
// Latency: done pulses WIDTH+2 edges after the accept edge (1 setup + WIDTH iterations + 1 sign fix).
// Backpressure: start is only sampled while busy_o=0; requests while busy are dropped.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i, op_i        request and opcode (00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   a_i, b_i             operands, captured on the accept edge
//   busy_o, done_o       in-flight flag, one-cycle completion pulse
//   div_by_zero_o        set with done_o when a divide had a zero divisor
//   hi_o, lo_o           product halves / remainder and quotient
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   setup_q, setup_d;
    logic [1:0]             op_q, op_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic [WIDTH-1:0]       opnd_q, opnd_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic                   done_q, done_d;
    logic                   dbz_q, dbz_d;

    // ------------------------------------------------------------------
    // Operand conditioning and sign bookkeeping
    // ------------------------------------------------------------------
    logic                   is_div;
    logic                   neg_a;
    logic                   neg_b;
    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH-1:0]       mag_b;
    logic                   b_zero;

    assign is_div = op_q[1];
    assign neg_a  = op_q[0] & a_q[WIDTH-1];
    assign neg_b  = op_q[0] & b_q[WIDTH-1];
    // Most-negative stays most-negative under negation, which reads
    // correctly as the unsigned magnitude 2^(WIDTH-1).
    assign mag_a  = neg_a ? -a_q : a_q;
    assign mag_b  = neg_b ? -b_q : b_q;
    assign b_zero = (b_q == '0);

    // ------------------------------------------------------------------
    // One multiply step: acc = {partial_hi, remaining multiplier bits}.
    // Add the multiplicand to the upper half when the multiplier LSB is set,
    // then shift the whole {carry, acc} right by one.
    // ------------------------------------------------------------------
    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // One restoring-divide step: acc = {remainder, dividend/quotient}.
    // Shift the next dividend bit into the remainder, subtract when it fits,
    // and shift the quotient bit into the low end.
    // ------------------------------------------------------------------
    logic [WIDTH:0]         div_shift;
    logic                   div_ge;
    logic [WIDTH-1:0]       div_diff;
    logic [2*WIDTH-1:0]     div_next;

    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    // Only used when div_ge, where the true difference fits in WIDTH bits.
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    assign div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ge};

    // ------------------------------------------------------------------
    // Sign fix-up applied when leaving FIN
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       quo_fix;
    logic [WIDTH-1:0]       rem_fix;

    assign prod_fix = (neg_a ^ neg_b) ? -acc_q : acc_q;
    assign quo_fix  = (neg_a ^ neg_b) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    // Remainder follows the dividend's sign (truncating division).
    assign rem_fix  = neg_a ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        setup_d = setup_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_CALC;
                    count_d = '0;
                    setup_d = 1'b1;
                    op_d    = op_i;
                    a_d     = a_i;
                    b_d     = b_i;
                end
            end

            S_CALC: begin
                if (setup_q) begin
                    // Magnitudes are formed here rather than on the accept
                    // edge to keep the negation off the operand input path.
                    // Both ops start from acc = {0, |a|}, opnd = |b|.
                    setup_d = 1'b0;
                    acc_d   = {{WIDTH{1'b0}}, mag_a};
                    opnd_d  = mag_b;
                end else begin
                    acc_d   = is_div ? div_next : mul_next;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WIDTH-1)) begin
                        state_d = S_FIN;
                    end
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!is_div) begin
                    hi_d  = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d  = prod_fix[WIDTH-1:0];
                    dbz_d = 1'b0;
                end else if (b_zero) begin
                    hi_d  = a_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else begin
                    hi_d  = rem_fix;
                    lo_d  = quo_fix;
                    dbz_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            count_q <= '0;
            setup_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            setup_q <= setup_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign div_by_zero_o = dbz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus randomized operations against
// an arithmetic reference model. Outputs are sampled on the falling clock edge.
module tb_mul_div_unit;

    logic        clk;
    logic        rst_ni;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy_o;
    logic        done_o;
    logic        div_by_zero_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .op_i          (op_i),
        .a_i           (a_i),
        .b_i           (b_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .div_by_zero_o (div_by_zero_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference model: returns {div_by_zero, hi, lo}.
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb, sq, sr;
        logic [63:0] uq, ur;
        case (op)
            2'd0: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b0, p};
            end
            2'd1: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                return {1'b0, p};
            end
            2'd2: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                uq = {32'b0, a} / {32'b0, b};
                ur = {32'b0, a} % {32'b0, b};
                return {1'b0, ur[31:0], uq[31:0]};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                sq = sa / sb;
                sr = sa % sb;
                uq = 64'(sq);
                ur = 64'(sr);
                return {1'b0, ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [6];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        corners[5] = 32'h0000_0007;
        if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 5)];
        if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 1000));
        return $urandom;
    endfunction

    // Issues one operation (caller sits at a falling edge), waits for done, and
    // reports results, edges from accept to done, and whether busy/hold behaved.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output logic dbz,
                          output int lat, output logic hold_ok, output logic busy_ok);
        logic [31:0] hi0, lo0;
        int          e0;
        bit          seen;
        hi0 = hi_o; lo0 = lo_o;
        hold_ok = 1'b1; busy_ok = 1'b1; lat = -1; seen = 1'b0;
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(posedge clk);
        @(negedge clk);
        e0 = edge_cnt;
        // Operand changes during busy must have no effect.
        start_i = 1'b0; op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (done_o) begin
                seen = 1'b1;
                lat  = edge_cnt - e0;
                if (busy_o) busy_ok = 1'b0;
            end else begin
                if (!busy_o) busy_ok = 1'b0;
                if (hi_o !== hi0 || lo_o !== lo0) hold_ok = 1'b0;
                @(negedge clk);
            end
        end
        hi = hi_o; lo = lo_o; dbz = div_by_zero_o;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; start_i = 1'b0; op_i = 2'd0; a_i = 32'd0; b_i = 32'd0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_o); end
        n_checks++; if (div_by_zero_o !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero_o); end
        n_checks++; if ({hi_o, lo_o} !== 64'd0) begin n_fail++; $display("FAIL reset_hilo: got %h_%h expected 0_0", hi_o, lo_o); end
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        logic [31:0] hi, lo; logic dbz, hold, bsy; int lat;
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, hi, lo, dbz, lat, hold, bsy);
        n_checks++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL multu_max: got %h_%h expected fffffffe_00000001", hi, lo); end
        n_checks++; if (lat != 34) begin n_fail++; $display("FAIL multu_latency: got %0d expected 34", lat); end
        n_checks++; if (bsy !== 1'b1) begin n_fail++; $display("FAIL multu_busy_window: got %b expected 1", bsy); end
        n_checks++; if (hold !== 1'b1) begin n_fail++; $display("FAIL multu_hold: got %b expected 1", hold); end
        n_checks++; if (dbz !== 1'b0) begin n_fail++; $display("FAIL multu_dbz: got %b expected 0", dbz); end
        @(negedge clk);
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b expected 0", done_o); end
        run_op(2'd1, 32'hFFFF_FFFD, 32'd7, hi, lo, dbz, lat, hold, bsy);
        n_checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_fail++; $display("FAIL mult_neg3x7: got %h_%h expected ffffffff_ffffffeb", hi, lo); end
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, hi, lo, dbz, lat, hold, bsy);
        n_checks++; if ({hi, lo} !== 64'h0000_0000_0000_0001) begin n_fail++; $display("FAIL mult_m1xm1: got %h_%h expected 00000000_00000001", hi, lo); end
    endtask

    task automatic test_div();
        logic [31:0] hi, lo; logic dbz, hold, bsy; int lat;
        run_op(2'd2, 32'd100, 32'd7, hi, lo, dbz, lat, hold, bsy);
        n_checks++; if ({dbz, hi, lo} !== {1'b0, 32'd2, 32'd14}) begin n_fail++; $display("FAIL divu_100_7: got dbz=%b %h_%h expected dbz=0 00000002_0000000e", dbz, hi, lo); end
        n_checks++; if (lat != 34) begin n_fail++; $display("FAIL divu_latency: got %0d expected 34", lat); end
        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, hi, lo, dbz, lat, hold, bsy);
        n_checks++; if ({dbz, hi, lo} !== {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin n_fail++; $display("FAIL div_m7_2: got dbz=%b %h_%h expected dbz=0 ffffffff_fffffffd", dbz, hi, lo); end
        run_op(2'd2, 32'd5, 32'd0, hi, lo, dbz, lat, hold, bsy);
        n_checks++; if ({dbz, hi, lo} !== {1'b1, 32'd5, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL divu_by_zero: got dbz=%b %h_%h expected dbz=1 00000005_ffffffff", dbz, hi, lo); end
        n_checks++; if (lat != 34) begin n_fail++; $display("FAIL div0_latency: got %0d expected 34", lat); end
        run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, hi, lo, dbz, lat, hold, bsy);
        n_checks++; if ({dbz, hi, lo} !== {1'b0, 32'd0, 32'h8000_0000}) begin n_fail++; $display("FAIL div_overflow: got dbz=%b %h_%h expected dbz=0 00000000_80000000", dbz, hi, lo); end
    endtask

    task automatic test_random();
        logic [31:0] hi, lo, a, b; logic [1:0] op; logic dbz, hold, bsy; int lat;
        logic [64:0] exp;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a = pick_operand();
            b = pick_operand();
            exp = model(op, a, b);
            run_op(op, a, b, hi, lo, dbz, lat, hold, bsy);
            n_checks++; if ({dbz, hi, lo} !== exp) begin n_fail++; $display("FAIL rand_result op=%0d a=%h b=%h: got dbz=%b %h_%h expected dbz=%b %h_%h", op, a, b, dbz, hi, lo, exp[64], exp[63:32], exp[31:0]); end
            n_checks++; if (lat != 34) begin n_fail++; $display("FAIL rand_latency op=%0d: got %0d expected 34", op, lat); end
            n_checks++; if ({hold, bsy} !== 2'b11) begin n_fail++; $display("FAIL rand_hold_busy op=%0d: got hold=%b busy=%b expected 1 1", op, hold, bsy); end
            // Occasionally idle between operations; otherwise issue back-to-back.
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic test_ignore_and_back_to_back();
        logic [31:0] hi, lo; logic dbz, hold, bsy; int lat, e0;
        bit seen;
        start_i = 1'b1; op_i = 2'd0; a_i = 32'd3; b_i = 32'd4;
        @(posedge clk);
        @(negedge clk);
        e0 = edge_cnt;
        start_i = 1'b0;
        repeat (6) @(negedge clk);
        start_i = 1'b1; op_i = 2'd2; a_i = 32'd9; b_i = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        seen = 1'b0; lat = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (done_o) begin seen = 1'b1; lat = edge_cnt - e0; end
            else @(negedge clk);
        end
        n_checks++; if ({div_by_zero_o, hi_o, lo_o} !== {1'b0, 32'd0, 32'd12}) begin n_fail++; $display("FAIL ignore_busy_start: got dbz=%b %h_%h expected dbz=0 00000000_0000000c", div_by_zero_o, hi_o, lo_o); end
        n_checks++; if (lat != 34) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 34", lat); end
        // Still in the done cycle: this start must be accepted.
        run_op(2'd0, 32'd5, 32'd7, hi, lo, dbz, lat, hold, bsy);
        n_checks++; if ({hi, lo} !== {32'd0, 32'd35}) begin n_fail++; $display("FAIL back_to_back: got %h_%h expected 00000000_00000023", hi, lo); end
        n_checks++; if (lat != 34) begin n_fail++; $display("FAIL back_to_back_latency: got %0d expected 34", lat); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] hi, lo; logic dbz, hold, bsy; int lat, dcount;
        start_i = 1'b1; op_i = 2'd2; a_i = 32'd1000; b_i = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (11) @(negedge clk);
        rst_ni = 1'b0;
        #1;
        n_checks++; if ({busy_o, done_o, div_by_zero_o} !== 3'b000) begin n_fail++; $display("FAIL midreset_flags: got busy=%b done=%b dbz=%b expected 0 0 0", busy_o, done_o, div_by_zero_o); end
        n_checks++; if ({hi_o, lo_o} !== 64'd0) begin n_fail++; $display("FAIL midreset_hilo: got %h_%h expected 0_0", hi_o, lo_o); end
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        dcount = 0;
        repeat (60) begin
            @(negedge clk);
            if (done_o || busy_o) dcount++;
        end
        n_checks++; if (dcount != 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d active cycles expected 0", dcount); end
        run_op(2'd0, 32'd2, 32'd3, hi, lo, dbz, lat, hold, bsy);
        n_checks++; if ({dbz, hi, lo} !== {1'b0, 32'd0, 32'd6}) begin n_fail++; $display("FAIL after_reset_mul: got dbz=%b %h_%h expected dbz=0 00000000_00000006", dbz, hi, lo); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_random();
        test_ignore_and_back_to_back();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
